// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding request/response port to APB3 master,
// with one-hot slave decode, decode-error responses and an ACCESS-phase timeout.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             arstn,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pslverr
);
    localparam int SEL_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state;
    logic [SEL_W-1:0]      idx;
    logic [SEL_W-1:0]      req_idx;
    logic [CNT_W-1:0]      cnt;
    logic                  sel_ready;
    logic                  sel_err;
    logic                  timed_out;
    logic [DATA_WIDTH-1:0] sel_rdata;

    assign req_ready = state == IDLE;
    assign req_idx   = req_addr[SEL_LSB +: SEL_W];
    assign sel_ready = pready[idx];
    assign sel_err   = pslverr[idx];
    assign sel_rdata = prdata[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    // A slave answering on the last allowed cycle still wins over the abort.
    assign timed_out = TIMEOUT_CYCLES != 0 && cnt == CNT_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    if (int'(req_idx) >= NUM_SLAVES) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        state  <= SETUP;
                        idx    <= req_idx;
                        psel   <= NUM_SLAVES'(1) << req_idx;
                        pwrite <= req_write;
                        paddr  <= req_addr;
                        pwdata <= req_wdata;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                    cnt     <= '0;
                end
                ACCESS: if (sel_ready || timed_out) begin
                    state     <= IDLE;
                    psel      <= '0;
                    penable   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= sel_ready ? sel_err : 1'b1;
                    rsp_rdata <= sel_ready && !pwrite ? sel_rdata : '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_psel_onehot: assert property (@(posedge clk) disable iff (!arstn) $onehot0(psel));
    a_penable_sel: assert property (@(posedge clk) disable iff (!arstn) penable |-> |psel);
    a_stable: assert property (@(posedge clk) disable iff (!arstn)
        state == ACCESS |-> $stable(paddr) && $stable(pwrite) && $stable(pwdata));
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed vectors against three slave models
// (zero-wait, registered-PREADY gpio, controllable stall slave).
module tb_apb_master_bridge;
    localparam int NS = 3;

    typedef struct {
        logic          w;
        logic [31:0]   a;
        logic [31:0]   d;
        logic [31:0]   rd;
        logic          er;
        int            lat;
        logic [NS-1:0] ps;
    } vec_t;

    logic           clk = 1'b0;
    logic           arstn = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_write = 1'b0;
    logic [31:0]    req_addr = '0;
    logic [31:0]    req_wdata = '0;
    logic           rsp_valid;
    logic [31:0]    rsp_rdata;
    logic           rsp_err;
    logic [NS-1:0]  psel;
    logic           penable;
    logic           pwrite;
    logic [31:0]    paddr;
    logic [31:0]    pwdata;
    logic [NS-1:0]  pready;
    logic [NS*32-1:0] prdata;
    logic [NS-1:0]  pslverr;

    int checks = 0;
    int failures = 0;

    logic        s0_err = 1'b0;
    logic        s2_ready = 1'b1;
    logic        s2_late = 1'b0;
    logic [31:0] s2_data = 32'h0000_CAFE;
    logic        p1_q;
    logic [31:0] s1_mem [4];
    int          s2_acc;
    vec_t        v [10];

    always #5 clk = ~clk;

    apb_master_bridge #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .arstn(arstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    // slave 0 zero-wait, slave 1 gpio with registered PREADY, slave 2 stall/late-ready
    assign pready  = {s2_ready | (s2_late & psel[2] & penable & (s2_acc == 15)), p1_q, 1'b1};
    assign prdata  = {s2_data, s1_mem[paddr[3:2]], 32'h0BAD_F00D};
    assign pslverr = {2'b00, s0_err};

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            p1_q   <= 1'b0;
            s2_acc <= 0;
        end else begin
            p1_q   <= psel[1] & penable & ~p1_q;
            s2_acc <= (psel[2] & penable) ? s2_acc + 1 : 0;
            if (psel[1] & penable & p1_q & pwrite) s1_mem[paddr[3:2]] <= pwdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int acc, output logic [31:0] rd,
                        output logic er, output logic [NS-1:0] ps);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
        ps  = psel;
        lat = 1;
        acc = 0;
        while (!rsp_valid && lat < 64) begin
            step();
            lat++;
            acc += int'(penable);
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic run(input string name, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] e_rd, input logic e_er, input int e_lat, input logic [NS-1:0] e_ps);
        int lat, acc;
        logic [31:0] rd;
        logic er;
        logic [NS-1:0] ps;
        xfer(w, a, d, lat, acc, rd, er, ps);
        chk({name, ".lat"}, 32'(lat), 32'(e_lat));
        chk({name, ".rdata"}, rd, e_rd);
        chk({name, ".err"}, 32'(er), 32'(e_er));
        chk({name, ".psel"}, 32'(ps), 32'(e_ps));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, acc;
        logic [31:0] rd;
        logic er;
        logic [NS-1:0] ps;
        logic seen;
        v[0] = '{1'b1, 32'h1000, 32'h0000_00FF, 32'h0,         1'b0, 4, 3'b010};
        v[1] = '{1'b1, 32'h1008, 32'hA5A5_5A5A, 32'h0,         1'b0, 4, 3'b010};
        v[2] = '{1'b0, 32'h1008, 32'h0,         32'hA5A5_5A5A, 1'b0, 4, 3'b010};
        v[3] = '{1'b0, 32'h1000, 32'h0,         32'h0000_00FF, 1'b0, 4, 3'b010};
        v[4] = '{1'b0, 32'h3000, 32'h0,         32'h0,         1'b1, 1, 3'b000};
        v[5] = '{1'b1, 32'h3FFC, 32'h1,         32'h0,         1'b1, 1, 3'b000};
        v[6] = '{1'b1, 32'h0004, 32'hDEAD_BEEF, 32'h0,         1'b0, 3, 3'b001};
        v[7] = '{1'b0, 32'h0000, 32'h0,         32'h0BAD_F00D, 1'b0, 3, 3'b001};
        v[8] = '{1'b0, 32'h2000, 32'h0,         32'h0000_CAFE, 1'b0, 3, 3'b100};
        v[9] = '{1'b1, 32'h2004, 32'h5,         32'h0,         1'b0, 3, 3'b100};

        #1 arstn = 1'b0;
        #1;
        chk("reset.psel", 32'(psel), 32'h0);
        chk("reset.penable", 32'(penable), 32'h0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset.req_ready", 32'(req_ready), 32'h1);
        chk("reset.paddr", paddr, 32'h0);
        step();
        step();
        arstn = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run($sformatf("vec%0d", i), v[i].w, v[i].a, v[i].d, v[i].rd, v[i].er, v[i].lat, v[i].ps);
            if (i == 0) chk("gpio_en", s1_mem[0], 32'h0000_00FF);
        end

        step();
        chk("pulse.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("pulse.rsp_err", 32'(rsp_err), 32'h0);
        chk("pulse.rsp_rdata", rsp_rdata, 32'h0);

        run("b2b_first", 1'b0, 32'h1008, 32'h0, 32'hA5A5_5A5A, 1'b0, 4, 3'b010);
        chk("b2b.req_ready", 32'(req_ready), 32'h1);
        run("b2b_second", 1'b0, 32'h1000, 32'h0, 32'h0000_00FF, 1'b0, 4, 3'b010);

        s2_ready = 1'b0;
        xfer(1'b0, 32'h2004, 32'h0, lat, acc, rd, er, ps);
        chk("timeout.acc_cycles", 32'(acc), 32'd16);
        chk("timeout.lat", 32'(lat), 32'd18);
        chk("timeout.err", 32'(er), 32'h1);
        chk("timeout.rdata", rd, 32'h0);
        chk("timeout.psel_idle", 32'(psel), 32'h0);

        s2_late = 1'b1;
        s2_data = 32'h0000_1234;
        xfer(1'b0, 32'h2000, 32'h0, lat, acc, rd, er, ps);
        chk("late.acc_cycles", 32'(acc), 32'd16);
        chk("late.err", 32'(er), 32'h0);
        chk("late.rdata", rd, 32'h0000_1234);
        s2_late = 1'b0;

        s0_err = 1'b1;
        run("slverr", 1'b0, 32'h0000, 32'h0, 32'h0BAD_F00D, 1'b1, 3, 3'b001);
        s0_err = 1'b0;

        step();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h2000;
        step();
        req_valid = 1'b0;
        step();
        chk("rst_mid.penable_before", 32'(penable), 32'h1);
        chk("rst_mid.psel_before", 32'(psel), 32'b100);
        #2 arstn = 1'b0;
        #1;
        chk("rst_mid.psel_async", 32'(psel), 32'h0);
        chk("rst_mid.penable_async", 32'(penable), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen |= rsp_valid;
        end
        #3 arstn = 1'b1;
        step();
        seen |= rsp_valid;
        chk("rst_mid.no_rsp", 32'(seen), 32'h0);
        chk("rst_mid.req_ready", 32'(req_ready), 32'h1);
        s2_ready = 1'b1;
        run("post_rst_wr", 1'b1, 32'h1004, 32'h0000_0077, 32'h0, 1'b0, 4, 3'b010);
        run("post_rst_rd", 1'b0, 32'h1004, 32'h0, 32'h0000_0077, 1'b0, 4, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
